// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_time_counter
// Description : Counts 10 ms ticks into packed-BCD MM:SS.CC and owns the
//               IDLE / RUN / PAUSE control FSM of the stopwatch. It gates the
//               upstream tick generator (enable in RUN, clear in IDLE) and
//               drives the 7-segment display mux with BCD digits.
//
// Parameters  : MAX_MIN - highest minute value before rollover (1..99)
//               WRAP    - 1: wrap MAX_MIN:59.99 -> 00:00.00 and keep running
//                         0: saturate at MAX_MIN:59.99 and enter PAUSE
//
// Ports       : clk        in   system clock
//               rst        in   synchronous active-high reset
//               tick       in   one-cycle count pulse (counted only in RUN)
//               start_stop in   one-cycle pulse, toggles run/pause
//               clear      in   one-cycle pulse, zeroes the count in PAUSE
//               lap        in   one-cycle pulse, lap hold toggle (optional)
//               tick_ena   out  tick generator enable, 1 only in RUN
//               tick_clear out  tick generator clear, 1 only in IDLE
//               running    out  1 in RUN
//               rollover   out  one-cycle pulse when the maximum is passed
//               lap_active out  display frozen by lap hold
//               disp_cs    out  centiseconds {tens,ones} BCD
//               disp_sec   out  seconds {tens,ones} BCD
//               disp_min   out  minutes {tens,ones} BCD
//
// Option      : `define STOPWATCH_LAP_HOLD_EN to enable the lap-hold display
//               freeze. Without it lap is ignored and lap_active is 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_time_counter #(
    parameter int MAX_MIN = 59,
    parameter bit WRAP    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       tick_ena,
    output logic       tick_clear,
    output logic       running,
    output logic       rollover,
    output logic       lap_active,
    output logic [7:0] disp_cs,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_min
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;

    localparam logic [3:0] c_MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_MAX_MIN_ONES = 4'(MAX_MIN % 10);

    // Full count as {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, one nibble each.
    localparam logic [23:0] c_MAX_COUNT = {c_MAX_MIN_TENS, c_MAX_MIN_ONES,
                                           4'd5, 4'd9, 4'd9, 4'd9};

    logic [1:0]  r_state;
    logic [23:0] r_count;
    logic        r_rollover;
    logic [23:0] w_count_inc;
    logic [23:0] w_disp;
    logic        w_at_max;

    assign w_at_max = (r_count == c_MAX_COUNT);

    // One BCD step with ripple carry; w_at_max is handled before this is
    // used, so minute tens never has to step past 9.
    always_comb begin
        w_count_inc = r_count;
        if (r_count[3:0] != 4'd9) begin
            w_count_inc[3:0] = r_count[3:0] + 4'd1;
        end else begin
            w_count_inc[3:0] = 4'd0;
            if (r_count[7:4] != 4'd9) begin
                w_count_inc[7:4] = r_count[7:4] + 4'd1;
            end else begin
                w_count_inc[7:4] = 4'd0;
                if (r_count[11:8] != 4'd9) begin
                    w_count_inc[11:8] = r_count[11:8] + 4'd1;
                end else begin
                    w_count_inc[11:8] = 4'd0;
                    if (r_count[15:12] != 4'd5) begin
                        w_count_inc[15:12] = r_count[15:12] + 4'd1;
                    end else begin
                        w_count_inc[15:12] = 4'd0;
                        if (r_count[19:16] != 4'd9) begin
                            w_count_inc[19:16] = r_count[19:16] + 4'd1;
                        end else begin
                            w_count_inc[19:16] = 4'd0;
                            w_count_inc[23:20] = r_count[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_stop) r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (tick) begin
                        if (w_at_max) begin
                            r_rollover <= 1'b1;
                            if (WRAP) r_count <= '0;
                            else      r_state <= c_ST_PAUSE;
                        end else begin
                            r_count <= w_count_inc;
                        end
                    end
                    // A tick in the same cycle is still counted above.
                    if (start_stop) r_state <= c_ST_PAUSE;
                end
                c_ST_PAUSE: begin
                    // clear has priority over start_stop.
                    if (clear) begin
                        r_state <= c_ST_IDLE;
                        r_count <= '0;
                    end else if (start_stop) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_lap_active;
    logic [23:0] r_lap_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap_active <= 1'b0;
            r_lap_snap   <= '0;
        end else if (r_state == c_ST_PAUSE && clear) begin
            r_lap_active <= 1'b0;
        end else if (r_state == c_ST_RUN && lap) begin
            r_lap_active <= ~r_lap_active;
            // Freeze the value shown on the lap edge, before any tick update.
            if (!r_lap_active) r_lap_snap <= r_count;
        end
    end

    assign lap_active = r_lap_active;
    assign w_disp     = r_lap_active ? r_lap_snap : r_count;
`else
    logic w_lap_unused;
    assign w_lap_unused = lap;
    assign lap_active   = 1'b0;
    assign w_disp       = r_count;
`endif

    assign tick_ena   = (r_state == c_ST_RUN);
    assign running    = (r_state == c_ST_RUN);
    assign tick_clear = (r_state == c_ST_IDLE);
    assign rollover   = r_rollover;
    assign disp_min   = w_disp[23:16];
    assign disp_sec   = w_disp[15:8];
    assign disp_cs    = w_disp[7:0];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_time_counter
// Description : Scoreboard bench for stopwatch_time_counter. Three instances
//               (59/wrap, 1/wrap, 1/saturate) share one random + directed
//               stimulus stream; a time-in-centiseconds model predicts every
//               cycle's outputs, and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_time_counter;

    localparam int c_N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [c_N-1:0] ena, clr, run, roll, lapa;
    logic [7:0]     cs  [c_N];
    logic [7:0]     sec [c_N];
    logic [7:0]     mn  [c_N];

    always #5 clk = ~clk;

    stopwatch_time_counter #(.MAX_MIN(59), .WRAP(1'b1)) u_d0 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .tick_ena(ena[0]), .tick_clear(clr[0]),
        .running(run[0]), .rollover(roll[0]), .lap_active(lapa[0]),
        .disp_cs(cs[0]), .disp_sec(sec[0]), .disp_min(mn[0]));

    stopwatch_time_counter #(.MAX_MIN(1), .WRAP(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .tick_ena(ena[1]), .tick_clear(clr[1]),
        .running(run[1]), .rollover(roll[1]), .lap_active(lapa[1]),
        .disp_cs(cs[1]), .disp_sec(sec[1]), .disp_min(mn[1]));

    stopwatch_time_counter #(.MAX_MIN(1), .WRAP(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .tick_ena(ena[2]), .tick_clear(clr[2]),
        .running(run[2]), .rollover(roll[2]), .lap_active(lapa[2]),
        .disp_cs(cs[2]), .disp_sec(sec[2]), .disp_min(mn[2]));

    // ---------------- reference model ----------------
    // Time is kept as a plain integer of centiseconds.
    localparam int c_IDLE = 0, c_RUN = 1, c_PAUSE = 2;
    int m_maxmin [c_N] = '{59, 1, 1};
    bit m_wrap   [c_N] = '{1'b1, 1'b1, 1'b0};

    int m_state [c_N];
    int m_cnt   [c_N];
    int m_snap  [c_N];
    bit m_roll  [c_N];
    bit m_lap   [c_N];

    logic [28:0] exp_q [c_N][$];

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [28:0] expect_of(input int k);
        int shown;
        shown = m_lap[k] ? m_snap[k] : m_cnt[k];
        return {m_state[k] == c_RUN, m_state[k] == c_IDLE, m_state[k] == c_RUN,
                m_roll[k], m_lap[k],
                bcd(shown % 100), bcd((shown / 100) % 60), bcd(shown / 6000)};
    endfunction

    task automatic model_step(input int k, input logic t, input logic ss,
                              input logic cl, input logic lp, input logic r);
        int top;
        top = (m_maxmin[k] + 1) * 6000 - 1;
        if (r) begin
            m_state[k] = c_IDLE; m_cnt[k] = 0; m_roll[k] = 0; m_lap[k] = 0;
            m_snap[k] = 0;
            return;
        end
        m_roll[k] = 0;
        if (m_state[k] == c_IDLE) begin
            if (ss) m_state[k] = c_RUN;
        end else if (m_state[k] == c_RUN) begin
`ifdef STOPWATCH_LAP_HOLD_EN
            if (lp) begin
                if (!m_lap[k]) m_snap[k] = m_cnt[k];
                m_lap[k] = !m_lap[k];
            end
`endif
            if (t) begin
                if (m_cnt[k] == top) begin
                    m_roll[k] = 1;
                    if (m_wrap[k]) m_cnt[k] = 0;
                    else           m_state[k] = c_PAUSE;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (ss) m_state[k] = c_PAUSE;
        end else begin
            if (cl) begin
                m_state[k] = c_IDLE; m_cnt[k] = 0; m_lap[k] = 0;
            end else if (ss) begin
                m_state[k] = c_RUN;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic t, input logic ss, input logic cl,
                        input logic lp, input logic r);
        @(negedge clk);
        tick = t; start_stop = ss; clear = cl; lap = lp; rst = r;
        for (int k = 0; k < c_N; k++) begin
            model_step(k, t, ss, cl, lp, r);
            exp_q[k].push_back(expect_of(k));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [28:0] want, got;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < c_N; k++) begin
                if (exp_q[k].size() > 0) begin
                    want = exp_q[k].pop_front();
                    got  = {ena[k], clr[k], run[k], roll[k], lapa[k],
                            cs[k], sec[k], mn[k]};
                    total++;
                    if (got !== want) begin
                        bad++;
                        $display("FAIL outputs dut%0d t=%0t got=%h want=%h (ena,clr,run,roll,lap,cs,sec,min)",
                                 k, $time, got, want);
                    end
                end
            end
        end
    end

    initial begin
        // Reset and IDLE: ticks and clear are ignored.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Start, 5 ticks -> 00:00.05.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);

        // Run up to 01:59.99 (crosses 00:59.99 -> 01:00.00); clear ignored in RUN.
        for (int i = 0; i < 11994; i++)
            step(1'b1, 1'b0, 1'($urandom_range(0, 49) == 0), 1'b0, 1'b0);

        // Maximum for the MAX_MIN=1 instances: wrap vs saturate.
        ticks(4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Random phase.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1999) == 0));

        // 00:00.42, tick together with start_stop -> 43 then PAUSE.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(42);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // PAUSE with start_stop and clear together -> IDLE.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // clear in RUN is ignored; reset at 00:12.34 returns to IDLE.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1231);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Lap hold at 00:01.00, 50 ticks, release.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(50);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        // Lap in PAUSE is ignored; clear in PAUSE drops the hold.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Let the monitor drain the queues.
        @(posedge clk);
        @(posedge clk);
        #2;
        for (int k = 0; k < c_N; k++) begin
            total++;
            if (exp_q[k].size() != 0) begin
                bad++;
                $display("FAIL drain dut%0d left=%0d want=0", k, exp_q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Downstream consumer of the stopwatch tick generator.
- Counts single-cycle 10 ms ticks into packed-BCD centiseconds, seconds and minutes.
- Owns the run/pause/idle control FSM.
- Drives the tick generator's enable and clear so ticks only arrive while running. Feeds the 7-segment display mux.

Parameters:
- MAX_MIN, 59, highest minute value before rollover; legal range 1..99.
- WRAP, 1, 1 = wrap MAX_MIN:59.99 to 00:00.00 and keep running; 0 = saturate at MAX_MIN:59.99 and enter PAUSE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle count pulse from the tick generator
- start_stop  in  1  one-cycle pulse (debounced button): toggles run/pause
- clear  in  1  one-cycle pulse (debounced button): zero the count when paused
- lap  in  1  one-cycle pulse; used only with LAP_HOLD_EN
- tick_ena  out  1  enable to the tick generator; 1 only in RUN
- tick_clear  out  1  clear to the tick generator; 1 only in IDLE
- running  out  1  1 in RUN
- rollover  out  1  one-cycle pulse on reaching/passing the maximum
- lap_active  out  1  display frozen (LAP_HOLD_EN only, else 0)
- disp_cs  out  8  centiseconds, {tens,ones} BCD, 00..99
- disp_sec  out  8  seconds, {tens,ones} BCD, 00..59
- disp_min  out  8  minutes, {tens,ones} BCD, 00..MAX_MIN

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, all digits 0, tick_ena=0, tick_clear=1, running=0, rollover=0, lap_active=0.
- All outputs are registered or decoded from the state register; there are no combinational input-to-output paths.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start_stop goes to RUN; clear and tick are ignored.
  - RUN: tick increments the count; start_stop goes to PAUSE; clear is ignored.
  - PAUSE: start_stop goes to RUN; clear goes to IDLE and zeroes all digits.
  - PAUSE with start_stop and clear in the same cycle: clear wins, next state IDLE.
- tick and start_stop in the same RUN cycle: the tick is counted, then the state goes to PAUSE.
- Count update latency: the digit outputs change on the clk edge that samples tick=1; the new value is visible the following cycle.
- Ticks arriving outside RUN are dropped.
- Carry chain, one BCD step per tick:
  - cs ones 9->0 carries into cs tens.
  - cs 99->00 carries into sec ones.
  - sec 59->00 carries into min.
  - min ones 9->0 carries into min tens.
  - Digits never hold a non-BCD value.
- Maximum (MAX_MIN:59.99 plus a tick):
  - WRAP=1: all digits go to 0, rollover=1 for one cycle, state stays RUN.
  - WRAP=0: digits hold the maximum, rollover=1 for one cycle, state goes to PAUSE.
- Reset mid-run: returns to IDLE with zeroed digits on the same edge, overriding all other inputs.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - A lap pulse in RUN toggles lap_active.
  - While lap_active=1, disp_* hold the value latched on the lap edge; internal counting continues.
  - A second lap pulse releases the hold; disp_* show the live count the next cycle.
  - clear (entering IDLE) or reset forces lap_active=0.
  - lap is ignored in IDLE and PAUSE.
- Undefined: lap is ignored, lap_active is tied 0, disp_* always show the live count.

Test Plan:
- rst, then start_stop, then 5 ticks -> running=1, tick_ena=1, tick_clear=0, disp_cs=8'h05, sec=00, min=00.
- Preload via 5999 ticks, then 1 tick -> disp 00:59.99 becomes 01:00.00 (disp_min=8'h01, disp_sec=8'h00, disp_cs=8'h00).
- WRAP=1, MAX_MIN=1: reach 01:59.99, 1 tick -> 00:00.00, rollover high exactly 1 cycle, still RUN. WRAP=0: holds 01:59.99, state PAUSE, tick_ena=0.
- RUN at 00:00.42, start_stop together with tick -> 00:00.43 then PAUSE; further ticks leave 43; clear -> IDLE, all 0, tick_clear=1.
- PAUSE with start_stop and clear in the same cycle -> IDLE, digits 0. clear during RUN -> no change. rst during RUN at 00:12.34 -> IDLE, all 0 next cycle.
- STOPWATCH_LAP_HOLD_EN: lap at 00:01.00, then 50 ticks -> disp_cs=8'h00, disp_sec=8'h01, lap_active=1. Second lap -> disp shows 00:01.50, lap_active=0.
